// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) xtime, reduction constant, engine state type
// and a column slice helper for the 128-bit state layout.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Column 0 occupies the most significant word of the state.
    function automatic logic [31:0] get_col(input logic [127:0] st, input logic [1:0] c);
        logic [31:0] r;
        case (c)
            2'd0:    r = st[127:96];
            2'd1:    r = st[95:64];
            2'd2:    r = st[63:32];
            default: r = st[31:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_mix_col.sv
// Combinational forward MixColumns for a single 32-bit column.
module aes_mix_col
    import aes_pkg::*;
(
    input  logic [7:0]  s0,
    input  logic [7:0]  s1,
    input  logic [7:0]  s2,
    input  logic [7:0]  s3,
    output logic [31:0] col_out
);

    logic [7:0] x0, x1, x2, x3;
    logic [7:0] o0, o1, o2, o3;

    always_comb begin
        x0 = xtime(s0);
        x1 = xtime(s1);
        x2 = xtime(s2);
        x3 = xtime(s3);
        // 3b is folded in as xtime(b) ^ b
        o0 = x0 ^ (x1 ^ s1) ^ s2 ^ s3;
        o1 = s0 ^ x1 ^ (x2 ^ s2) ^ s3;
        o2 = s0 ^ s1 ^ x2 ^ (x3 ^ s3);
        o3 = (x0 ^ s0) ^ s1 ^ s2 ^ x3;
        col_out = {o0, o1, o2, o3};
    end

endmodule

// File: rtl/aes_mix_cols_iter.sv
// Iterative forward MixColumns engine: one column per clock through a single
// shared mixer, valid/ready on both sides with overlapped accept in DONE.
module aes_mix_cols_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    state_t        state, state_nxt;
    logic [1:0]    col;
    logic [127:0]  work;
    logic [127:0]  work_wb;
    logic [31:0]   cur_col;
    logic [31:0]   mix_col;
    logic          load;

    assign cur_col  = get_col(work, col);
    assign out_data = work;
    assign load     = in_valid & in_ready;

    aes_mix_col u_mix (
        .s0      (cur_col[31:24]),
        .s1      (cur_col[23:16]),
        .s2      (cur_col[15:8]),
        .s3      (cur_col[7:0]),
        .col_out (mix_col)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (col == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        work_wb = work;
        for (int unsigned i = 0; i < 4; i++) begin
            if (col == 2'(i)) work_wb[127 - 32*i -: 32] = mix_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                work <= in_data;
                col  <= '0;
            end else if (state == BUSY) begin
                work <= work_wb;
                // col parks at 3 until the next load rather than wrapping
                if (col != 2'd3) col <= col + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_mix_cols_iter.sv
// Self-checking bench for aes_mix_cols_iter against a GF(2^8) matrix model.
module tb_aes_mix_cols_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int errors = 0;
    int checks = 0;

    aes_mix_cols_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st);
        logic [7:0] m [4][4];
        logic [7:0] s [4];
        logic [7:0] o;
        logic [127:0] r;
        m[0] = '{8'd2, 8'd3, 8'd1, 8'd1};
        m[1] = '{8'd1, 8'd2, 8'd3, 8'd1};
        m[2] = '{8'd1, 8'd1, 8'd2, 8'd3};
        m[3] = '{8'd3, 8'd1, 8'd1, 8'd2};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) s[k] = st[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                o = '0;
                for (int k = 0; k < 4; k++) o = o ^ gmul(m[row][k], s[k]);
                r[127 - 32*c - 8*row -: 8] = o;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_one(input logic [127:0] d, input logic [127:0] exp, input string name);
        int n;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL %s latency: got %0d want 4", name, n);
        end
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, out_data, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: out_valid got %b want 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h want 1 0 0",
                     in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_fips();
        run_one(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                128'h046681e5_e0cb199a_48f8d37a_2806264c, "fips_b_round1");
    endtask

    task automatic test_columns();
        run_one(128'hdb135345_f20a225c_01010101_2d26314c,
                128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, "column_vectors");
    endtask

    task automatic test_random();
        logic [127:0] d;
        for (int i = 0; i < 12; i++) begin
            d = rand128();
            run_one(d, model(d), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b;
        int t_seen [$];
        logic [127:0] d_seen [$];
        a = rand128();
        b = rand128();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = a;
        @(negedge clk);
        in_data = b;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                t_seen.push_back(t);
                d_seen.push_back(out_data);
            end
            if (t == 5) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        checks++;
        if (t_seen.size() != 2) begin
            errors++;
            $display("FAIL b2b count: got %0d results want 2", t_seen.size());
        end else begin
            checks++;
            if (t_seen[0] != 4 || t_seen[1] != 9) begin
                errors++;
                $display("FAIL b2b timing: got t=%0d,%0d want 4,9", t_seen[0], t_seen[1]);
            end
            checks++;
            if (d_seen[0] !== model(a) || d_seen[1] !== model(b)) begin
                errors++;
                $display("FAIL b2b data: got %h / %h want %h / %h",
                         d_seen[0], d_seen[1], model(a), model(b));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, exp;
        int n;
        int bad;
        a = rand128();
        exp = model(a);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = a;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        // A competing state is offered while the result is stalled.
        in_valid = 1'b1;
        in_data  = rand128();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure hold: %0d bad cycles want 0 (out_data=%h want %h)",
                     bad, out_data, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_data !== exp) begin
            errors++;
            $display("FAIL backpressure release: in_ready=%b data=%h want 1 %h",
                     in_ready, out_data, exp);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure idle: out_valid=%b in_ready=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rand128();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_reset: out_valid=%b out_data=%h in_ready=%b want 0 0 1",
                     out_valid, out_data, in_ready);
        end
        run_one(128'hc6c6c6c6_d4d4d4d5_01010101_2d26314c,
                128'hc6c6c6c6_d5d5d7d6_01010101_4d7ebdf8, "post_reset");
    endtask

    task automatic test_ignore_busy();
        logic [127:0] a;
        int n;
        a = rand128();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = a;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = rand128();
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL ignore_busy latency: got %0d want 4", n);
        end
        checks++;
        if (out_data !== model(a)) begin
            errors++;
            $display("FAIL ignore_busy data: got %h want %h", out_data, model(a));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fips();
        test_columns();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_busy();
        test_ignore_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
